sobel_scheduler: RTL and testbench
==================================

SOBEL_SCHEDULER -- requirements
Module: sobel_scheduler

Interface
REQ-001 Parameter IMG_W, default 640: image width in pixels; legal range 3..2047.
REQ-002 Parameter IMG_H, default 480: image height in pixels; legal range 3..2047.
REQ-003 Parameter ADDR_W, default 19: width of the frame-memory address, with IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to process one frame.
REQ-007 busy  out  1  frame in progress.
REQ-008 done  out  1  one-cycle pulse at frame end.
REQ-009 rd_en  out  1  source-frame read strobe.
REQ-010 rd_addr  out  ADDR_W  source address y*IMG_W+x.
REQ-011 rd_data  in  24  RGB pixel, valid exactly 1 cycle after rd_en.
REQ-012 p0..p7  out  24 each  kernel window: p0 TL, p1 T, p2 TR, p3 L, p4 R, p5 BL, p6 B, p7 BR (centre excluded).
REQ-013 hc, vc  out  11 each  centre coordinate of the current window.
REQ-014 win_valid  out  1  window and hc/vc valid this cycle.
REQ-015 res_in  in  11  combinational kernel magnitude for the presented window (0..1442).
REQ-016 wr_en  out  1  result write strobe.
REQ-017 wr_addr  out  ADDR_W  result address vc*IMG_W+hc.
REQ-018 wr_data  out  24  {s,s,s}, s = saturated res_in.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last read issued; DRAIN->DONE after last write; DONE->IDLE unconditionally after 1 cycle.
REQ-020 start is ignored in every state other than IDLE.
REQ-021 busy=1 in RUN and DRAIN, 0 in IDLE and DONE; done=1 only in DONE.
REQ-022 In RUN, rd_en=1 every cycle, raster order x=0..IMG_W-1 inner, y=0..IMG_H-1 outer; exactly IMG_W*IMG_H reads, no gaps, no repeats.
REQ-023 Two line buffers of IMG_W x 24 bits hold rows y-1 and y-2; a 3x3 register window shifts one column per returned pixel.
REQ-024 Pixel read at cycle t for (x,y) completes the window centred on (x-1,y-1); win_valid=1 at cycle t+2 iff x>=2 and y>=2.
REQ-025 hc=x-1, vc=y-1 during win_valid; p0..p7, hc, vc unchanged when win_valid=0.
REQ-026 wr_en=win_valid in the same cycle; only interior pixels (1..IMG_W-2, 1..IMG_H-2) are written; border pixels are never written.
REQ-027 Exactly (IMG_W-2)*(IMG_H-2) writes per frame, in raster order.
REQ-028 s = res_in when res_in <= 255, else 255.
REQ-029 Row wrap: window columns from the previous row never contribute to a window on the new row; the first two pixels of each row produce no win_valid.
REQ-030 DRAIN holds rd_en=0 and lasts until the write for (IMG_W-2,IMG_H-2) has been issued; DONE is entered the following cycle.
REQ-031 Frame latency: done asserted exactly IMG_W*IMG_H+2 cycles after the cycle in which the first read was issued.

Reset
REQ-032 reset=0 at a rising edge forces IDLE, including in mid-frame; the frame is abandoned and not resumed.
REQ-033 Reset values: busy=0, done=0, rd_en=0, rd_addr=0, win_valid=0, wr_en=0, wr_addr=0, wr_data=0, hc=0, vc=0, p0..p7=0, all x/y counters 0.
REQ-034 Line-buffer contents need not be cleared; no output depends on stale line-buffer data.

Verification
REQ-035 IMG_W=5, IMG_H=4, start pulse -> 20 consecutive reads at addr 0..19, 6 writes at addr 6,7,8,11,12,13, done at first-read cycle+22.
REQ-036 Ramp image rd_data=addr -> at first win_valid hc=1, vc=1, p0=0, p1=1, p2=2, p3=5, p4=7, p5=10, p6=11, p7=12.
REQ-037 res_in=1442 on every window -> every wr_data=24'hFFFFFF; res_in=200 -> 24'hC8C8C8.
REQ-038 start re-pulsed at read 7 of a frame -> ignored; read/write sequence identical to REQ-035.
REQ-039 reset=0 at read 10 -> next cycle all outputs at reset values; new start -> full correct frame from addr 0.
REQ-040 Back-to-back start in the cycle after done -> second frame identical in timing and counts to the first.

Source files
------------

// File: rtl/sobel_scheduler.sv
// sobel_scheduler: raster read sequencer feeding two line buffers and a 3x3
// window; presents each interior window to an external kernel and writes the
// saturated magnitude back at the window centre.
module sobel_scheduler #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       p0,
  output logic [23:0]       p1,
  output logic [23:0]       p2,
  output logic [23:0]       p3,
  output logic [23:0]       p4,
  output logic [23:0]       p5,
  output logic [23:0]       p6,
  output logic [23:0]       p7,
  output logic [10:0]       hc,
  output logic [10:0]       vc,
  output logic              win_valid,
  input  logic [10:0]       res_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data
);

  localparam int XW = $clog2(IMG_W);
  localparam logic [10:0] X_LAST  = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST  = 11'(IMG_H - 1);
  localparam logic [10:0] HC_LAST = 11'(IMG_W - 2);
  localparam logic [10:0] VC_LAST = 11'(IMG_H - 2);
  // distance from the newest pixel (x,y) back to the window centre (x-1,y-1)
  localparam logic [ADDR_W-1:0] CTR_OFS = ADDR_W'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                busy_q, done_q, rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [10:0]         x_q, y_q;

  // read-side coordinates delayed by one cycle, aligned with rd_data
  logic                s1_valid_q;
  logic [10:0]         s1_x_q, s1_y_q;
  logic [ADDR_W-1:0]   s1_addr_q;

  // line buffers: lb0 holds row y-1, lb1 holds row y-2
  logic [23:0]         lb0_mem [IMG_W];
  logic [23:0]         lb1_mem [IMG_W];
  logic [23:0]         lb0_rd_q, lb1_rd_q;

  // two previous window columns: index 0 = column x-2, 1 = column x-1;
  // row 0 = top (y-2), row 1 = middle (y-1), row 2 = bottom (y)
  logic [23:0]         col_q [2][3];
  logic [23:0]         col_d [3];

  logic [23:0]         p_q [8];
  logic [10:0]         hc_q, vc_q;
  logic                win_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          s_d;

  assign col_d[0] = lb1_rd_q;
  assign col_d[1] = lb0_rd_q;
  assign col_d[2] = rd_data;

  // Frame FSM: issues one read per RUN cycle, waits for the final write in DRAIN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
          end
        end
        RUN: begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 11'd1;
            end else begin
              x_q <= x_q + 11'd1;
            end
          end
        end
        DRAIN: begin
          if (win_valid_q && hc_q == HC_LAST && vc_q == VC_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay read coordinates so they line up with the returned pixel
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= rd_en_q;
      s1_x_q     <= x_q;
      s1_y_q     <= y_q;
      s1_addr_q  <= rd_addr_q;
    end
  end

  // Line-buffer RAMs: registered read at the column being fetched, write-back
  // of the returned pixel (and the row it displaces) one cycle later
  always_ff @(posedge clk) begin
    lb0_rd_q <= lb0_mem[x_q[XW-1:0]];
    lb1_rd_q <= lb1_mem[x_q[XW-1:0]];
    if (s1_valid_q) begin
      lb0_mem[s1_x_q[XW-1:0]] <= rd_data;
      lb1_mem[s1_x_q[XW-1:0]] <= lb0_rd_q;
    end
  end

  // Window shift and output capture; outputs only move on a valid window
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        col_q[0][r] <= '0;
        col_q[1][r] <= '0;
      end
      for (int i = 0; i < 8; i++) p_q[i] <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      win_valid_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      win_valid_q <= 1'b0;
      if (s1_valid_q) begin
        for (int r = 0; r < 3; r++) begin
          col_q[0][r] <= col_q[1][r];
          col_q[1][r] <= col_d[r];
        end
        // first two columns of each row hold the previous row's tail
        if (s1_x_q >= 11'd2 && s1_y_q >= 11'd2) begin
          win_valid_q <= 1'b1;
          p_q[0]      <= col_q[0][0];
          p_q[1]      <= col_q[1][0];
          p_q[2]      <= col_d[0];
          p_q[3]      <= col_q[0][1];
          p_q[4]      <= col_d[1];
          p_q[5]      <= col_q[0][2];
          p_q[6]      <= col_q[1][2];
          p_q[7]      <= col_d[2];
          hc_q        <= s1_x_q - 11'd1;
          vc_q        <= s1_y_q - 11'd1;
          wr_addr_q   <= s1_addr_q - CTR_OFS;
        end
      end
    end
  end

  assign s_d = (res_in > 11'd255) ? 8'hFF : res_in[7:0];

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign p0        = p_q[0];
  assign p1        = p_q[1];
  assign p2        = p_q[2];
  assign p3        = p_q[3];
  assign p4        = p_q[4];
  assign p5        = p_q[5];
  assign p6        = p_q[6];
  assign p7        = p_q[7];
  assign hc        = hc_q;
  assign vc        = vc_q;
  assign win_valid = win_valid_q;
  assign wr_en     = win_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = win_valid_q ? {s_d, s_d, s_d} : 24'h0;

endmodule

// File: tb/tb_sobel_scheduler.sv
// tb_sobel_scheduler: randomized frames on a 5x4 image, scoreboard of expected
// reads and writes built from an image-level reference model.
module tb_sobel_scheduler;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, rd_en, win_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [23:0]   rd_data, wr_data;
  logic [23:0]   p0, p1, p2, p3, p4, p5, p6, p7;
  logic [10:0]   hc, vc, res_in;

  always #5 clk = ~clk;

  sobel_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7),
    .hc(hc), .vc(vc), .win_valid(win_valid), .res_in(res_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    int               addr;
    logic [23:0]      data;
    int               hc;
    int               vc;
    logic [7:0][23:0] win;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          res_mode = 0;
  logic [23:0] img [N];
  int          exp_rd[$];
  wr_t         exp_wr[$];
  int          first_rd = -1;
  int          last_rd = -1;
  bit          done_seen = 1'b0;
  bit          pend = 1'b0;
  int          pend_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name, string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // stand-in kernel: deterministic function of the window, spans 0..1442
  function automatic logic [10:0] kfun(int mode, logic [7:0][23:0] w);
    int acc;
    acc = 0;
    if (mode == 1) return 11'd1442;
    if (mode == 2) return 11'd200;
    for (int i = 0; i < 8; i++) acc += int'(w[i][7:0]) + int'(w[i][15:8]);
    return 11'(acc % 1443);
  endfunction

  always_comb res_in = kfun(res_mode, {p7, p6, p5, p4, p3, p2, p1, p0});

  // source-frame memory: one-cycle read latency
  always @(negedge clk) begin
    pend     = rd_en;
    pend_idx = int'(rd_addr);
  end
  always @(posedge clk) begin
    #1;
    rd_data = (pend && pend_idx < N) ? img[pend_idx] : 24'($urandom);
  end

  // reference model: raster reads and interior windows from the image itself
  task automatic build_exp();
    exp_rd.delete();
    exp_wr.delete();
    for (int a = 0; a < N; a++) exp_rd.push_back(a);
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        wr_t w;
        int  k;
        int  r;
        k = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0)) begin
              w.win[k] = img[(y + dy) * W + (x + dx)];
              k++;
            end
        r = int'(kfun(res_mode, w.win));
        if (r > 255) r = 255;
        w.data = {8'(r), 8'(r), 8'(r)};
        w.addr = y * W + x;
        w.hc   = x;
        w.vc   = y;
        exp_wr.push_back(w);
      end
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a read, write or done
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        else chk("rd_gap", cyc - last_rd, 1);
        last_rd = cyc;
        chk("busy_in_run", busy, 1);
        if (exp_rd.size() == 0) fail_now("rd_extra", $sformatf("unexpected read addr %0d", rd_addr));
        else chk("rd_addr", rd_addr, exp_rd.pop_front());
      end
      if (wr_en || win_valid) chk("wr_en_eq_win_valid", wr_en, win_valid);
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          fail_now("wr_extra", $sformatf("unexpected write addr %0d", wr_addr));
        end else begin
          wr_t              e;
          logic [7:0][23:0] got;
          e   = exp_wr.pop_front();
          got = {p7, p6, p5, p4, p3, p2, p1, p0};
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("hc", hc, e.hc);
          chk("vc", vc, e.vc);
          for (int i = 0; i < 8; i++) chk($sformatf("p%0d", i), got[i], e.win[i]);
          $display("wr addr=%0d hc=%0d vc=%0d data=%h", wr_addr, hc, vc, wr_data);
        end
      end
      if (done) begin
        if (first_rd < 0) fail_now("done_spurious", "done without a frame in progress");
        else chk("done_latency", cyc - first_rd, N + 2);
        chk("busy_at_done", busy, 0);
        first_rd  = -1;
        done_seen = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(string tag);
    logic [7:0][23:0] got;
    got = {p7, p6, p5, p4, p3, p2, p1, p0};
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_hc"}, hc, 0);
    chk({tag, "_vc"}, vc, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_p%0d", tag, i), got[i], 0);
  endtask

  // entered and left just after a rising edge
  task automatic run_frame(bit ramp, int mode, bit repulse, bit abort_frame);
    int n;
    res_mode = mode;
    for (int a = 0; a < N; a++) img[a] = ramp ? 24'(a) : 24'($urandom);
    build_exp();
    done_seen = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;                       // read 0 in this cycle
    if (repulse) begin
      repeat (7) @(posedge clk); #1;    // read 7
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (abort_frame) begin
      repeat (10) @(posedge clk); #1;   // read 10
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      exp_rd.delete();
      exp_wr.delete();
      first_rd = -1;
      @(negedge clk);
      check_reset_vals("abort");
      @(posedge clk); #1;
      return;
    end
    n = 0;
    while (!done_seen && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_seen", done_seen, 1);
    chk("reads_left", exp_rd.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b1, 0, 1'b0, 1'b0);     // ramp image
    run_frame(1'b0, 0, 1'b0, 1'b0);     // back-to-back random frame
    run_frame(1'b0, 1, 1'b0, 1'b0);     // saturating magnitude
    run_frame(1'b0, 2, 1'b1, 1'b0);     // magnitude 200, start re-pulsed mid-frame
    run_frame(1'b0, 0, 1'b0, 1'b1);     // reset during read 10
    run_frame(1'b0, 0, 1'b0, 1'b0);     // full frame after abort
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
